tf_gen_ctrl_flex: RTL and testbench
===================================

Name: tf_gen_ctrl_flex

Overview:
Parametrised next-generation controller for the 2D-array twiddle-factor generator. It sequences the seed load, the modular-multiply (MM) chain and the write-back of twiddle factors for a runtime-selectable number of rows. Compared with the fixed controller it adds downstream backpressure (out_rdy), abort, and generic depth/latency/row count. It sits between the top-level NTT scheduler and the tf_engine/seed-bank array; one instance drives MM_NUM engines.

Parameters:
MM_NUM, 4, modular multipliers driven per cycle (seed bank banking factor)
SEED_NUM, 1024, seeds per row; DEPTH = SEED_NUM/MM_NUM (power of two, >=2)
MM_LAT, 5, cycles per MM step (phase counter range 0..MM_LAT-1), >=2
ROW_NUM_MAX, 4, maximum rows per job (power of two)
AW, $clog2(DEPTH), derived, address width
SW, $clog2(ROW_NUM_MAX), derived, sel_sr width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job start pulse; honoured only in IDLE
first  in  1  qualifies start: clear seed pointer
row_num  in  SW+1  rows in job, sampled on accepted start
out_rdy  in  1  downstream ready for vld data
abort  in  1  synchronous abort, any state
busy  out  1  high in every state except IDLE
load  out  1  seed load strobe to engine shift registers
en  out  1  MM/shift-register advance enable
ren  out  1  seed/MM bank read enable
wen  out  1  TF bank write enable
vld  out  1  TF output valid
addr_r  out  AW  read address
addr_w  out  AW  write address
sel_sr  out  SW  shift-register row select
sel_mm  out  1  0 at MM phase 0, else 1
done_row  out  1  one-cycle pulse after a row's last transfer
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset: state IDLE; all counters 0; every output 0 except sel_mm=1.
- Registers: state, phase (0..MM_LAT-1), seed_cnt (AW), seed_ptr (AW), row_cnt (SW+1), rows (latched row_num), sel_sr, done_row, done.
- IDLE: start=1 -> latch rows; if first, seed_ptr<=0; if row_num==0, go to DONE directly; else go to SEED. start while not IDLE is ignored.
- SEED (1 cycle): ren=1, addr_r=seed_ptr -> LOAD.
- LOAD (1 cycle): load=1; seed_ptr+=1 (wraps mod DEPTH); seed_cnt<=0; phase<=0 -> RUN.
- RUN:
  - en=1 unless stalled.
  - phase increments each unstalled cycle and wraps MM_LAT-1 -> 0.
  - sel_mm = (phase!=0); outside RUN sel_mm=1.
- Transfer point, phase==MM_LAT-1:
  - vld=1 and addr_w=seed_cnt, both combinational.
  - Stall when out_rdy=0: phase, seed_cnt and all other state hold; en=0; vld stays 1; wen=0.
  - On vld&out_rdy: wen=1; seed_cnt+=1.
  - MM prefetch: ren=1 with addr_r=seed_cnt+1 in the same cycle, only when seed_cnt!=DEPTH-1.
- Elsewhere addr_r=0 and ren=0 except in SEED.
- Row end (transfer with seed_cnt==DEPTH-1):
  - done_row pulses next cycle; sel_sr+=1 (wraps); row_cnt+=1.
  - If row_cnt+1==rows go to DONE, else go to SEED.
- DONE (1 cycle): done=1; row_cnt<=0 -> IDLE. sel_sr holds until the next accepted start, which clears it.
- abort (highest priority): next state IDLE; phase, seed_cnt, row_cnt and sel_sr clear; seed_ptr keeps its value; no done or done_row pulse; outputs are IDLE values from the next cycle.
- Timing with start in cycle 0 and no stall:
  - SEED in cycle 1, LOAD in cycle 2, first vld in cycle 2+MM_LAT.
  - Row period = DEPTH*MM_LAT + 2 cycles.
  - done rises 2 cycles after the final transfer (DONE state is registered).
- Widths: all counters wrap modulo their width; seed_cnt+1 prefetch never overflows because it is gated at DEPTH-1.

Test Plan:
Use SEED_NUM=32, MM_NUM=4 (DEPTH=8), MM_LAT=5, ROW_NUM_MAX=4.
- Reset mid-RUN (rst_n low in cycle 20) -> all outputs return to reset values asynchronously; busy=0, sel_mm=1.
- start+first, row_num=1, out_rdy=1 -> load in cycle 2; vld in cycles 7,12,...,42 with addr_w 0..7; prefetch addr_r 1..7; done_row in cycle 43; done in cycle 44; sel_sr=1.
- row_num=4, out_rdy=1 -> 4 SEED reads at addr_r 0,1,2,3; 4 done_row pulses 42 cycles apart; sel_sr ends at 0 (wrap); one done pulse.
- out_rdy low for 3 cycles at the third vld -> vld held 4 cycles; wen=1 only in the 4th; en=0 while stalled; addr_w stays 2; total latency +3.
- abort during row 2 of 4 -> IDLE next cycle; no done; next start without first reads seed at addr_r 2.
- start with row_num=0 -> DONE next cycle; done pulse in cycle 2; no load/ren/vld. A second start while busy changes nothing.

Source files
------------

// File: rtl/tf_gen_ctrl_flex_if.sv
// Purpose : scheduler <-> twiddle-factor controller bundle (job control in, engine/bank strobes out).
// Ports   : master = scheduler/downstream side (drives start/first/row_num/out_rdy/abort),
//           slave  = controller side (drives busy/load/en/ren/wen/vld/addresses/selects/done pulses).
interface tf_gen_ctrl_flex_if #(
    parameter int AW = 8,
    parameter int SW = 2
);
    // job control and downstream flow control
    logic          start;
    logic          first;
    logic [SW:0]   row_num;
    logic          out_rdy;
    logic          abort;

    // engine / bank control and status
    logic          busy;
    logic          load;
    logic          en;
    logic          ren;
    logic          wen;
    logic          vld;
    logic [AW-1:0] addr_r;
    logic [AW-1:0] addr_w;
    logic [SW-1:0] sel_sr;
    logic          sel_mm;
    logic          done_row;
    logic          done;

    modport master (
        output start, first, row_num, out_rdy, abort,
        input  busy, load, en, ren, wen, vld, addr_r, addr_w, sel_sr, sel_mm, done_row, done
    );

    modport slave (
        input  start, first, row_num, out_rdy, abort,
        output busy, load, en, ren, wen, vld, addr_r, addr_w, sel_sr, sel_mm, done_row, done
    );
endinterface

// File: rtl/tf_gen_ctrl_flex.sv
// Purpose : sequences seed load, MM chain and TF write-back for 0..2*ROW_NUM_MAX-1 rows per job.
// Latency : first vld 2+MM_LAT cycles after start; row period DEPTH*MM_LAT+2; done 2 cycles after last transfer.
// Backpr. : out_rdy low at the transfer phase freezes phase/counters, drops en/wen, holds vld.
// Ports   : clk, rst_n (async active-low); ctl = slave side of tf_gen_ctrl_flex_if.
module tf_gen_ctrl_flex #(
    parameter int MM_NUM      = 4,
    parameter int SEED_NUM    = 1024,
    parameter int MM_LAT      = 5,
    parameter int ROW_NUM_MAX = 4,
    parameter int DEPTH       = SEED_NUM / MM_NUM,
    parameter int AW          = $clog2(DEPTH),
    parameter int SW          = $clog2(ROW_NUM_MAX)
) (
    input  logic              clk,
    input  logic              rst_n,
    tf_gen_ctrl_flex_if.slave ctl
);
    localparam int PW = (MM_LAT > 1) ? $clog2(MM_LAT) : 1;
    localparam logic [PW-1:0] PH_LAST   = PW'(MM_LAT - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEED = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [AW-1:0] seed_cnt_q, seed_cnt_d;
    logic [AW-1:0] seed_ptr_q, seed_ptr_d;
    logic [SW:0]   row_cnt_q, row_cnt_d;
    logic [SW:0]   rows_q, rows_d;
    logic [SW-1:0] sel_sr_q, sel_sr_d;
    logic          done_row_q, done_row_d;
    logic          done_q, done_d;

    // transfer-point qualifiers shared by next-state and output logic
    logic phase_pt;
    logic stall;
    logic xfer;
    logic row_end;

    assign phase_pt = (state_q == S_RUN) && (phase_q == PH_LAST);
    assign stall    = phase_pt && !ctl.out_rdy;
    assign xfer     = phase_pt && ctl.out_rdy;
    assign row_end  = xfer && (seed_cnt_q == ADDR_LAST);

    // ------------------------------------------------------------------
    // state / datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            seed_cnt_q <= '0;
            seed_ptr_q <= '0;
            row_cnt_q  <= '0;
            rows_q     <= '0;
            sel_sr_q   <= '0;
            done_row_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            seed_cnt_q <= seed_cnt_d;
            seed_ptr_q <= seed_ptr_d;
            row_cnt_q  <= row_cnt_d;
            rows_q     <= rows_d;
            sel_sr_q   <= sel_sr_d;
            done_row_q <= done_row_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        seed_cnt_d = seed_cnt_q;
        seed_ptr_d = seed_ptr_q;
        row_cnt_d  = row_cnt_q;
        rows_d     = rows_q;
        sel_sr_d   = sel_sr_q;
        done_row_d = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctl.start) begin
                    rows_d    = ctl.row_num;
                    row_cnt_d = '0;
                    sel_sr_d  = '0;
                    if (ctl.first) begin
                        seed_ptr_d = '0;
                    end
                    state_d = (ctl.row_num == '0) ? S_DONE : S_SEED;
                end
            end
            S_SEED: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                seed_ptr_d = seed_ptr_q + 1'b1;
                seed_cnt_d = '0;
                phase_d    = '0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (!stall) begin
                    phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
                end
                if (xfer) begin
                    seed_cnt_d = seed_cnt_q + 1'b1;
                end
                if (row_end) begin
                    done_row_d = 1'b1;
                    sel_sr_d   = sel_sr_q + 1'b1;
                    row_cnt_d  = row_cnt_q + 1'b1;
                    state_d    = ((row_cnt_q + 1'b1) == rows_q) ? S_DONE : S_SEED;
                end
            end
            S_DONE: begin
                done_d    = 1'b1;
                row_cnt_d = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including pulses already decided this
        // cycle; seed_ptr is restored so an aborted LOAD does not consume a seed.
        if (ctl.abort) begin
            state_d    = S_IDLE;
            phase_d    = '0;
            seed_cnt_d = '0;
            row_cnt_d  = '0;
            sel_sr_d   = '0;
            seed_ptr_d = seed_ptr_q;
            done_row_d = 1'b0;
            done_d     = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // output logic
    // ------------------------------------------------------------------
    logic          busy_o;
    logic          load_o;
    logic          en_o;
    logic          ren_o;
    logic          wen_o;
    logic          vld_o;
    logic [AW-1:0] addr_r_o;
    logic [AW-1:0] addr_w_o;
    logic          sel_mm_o;

    always_comb begin
        busy_o   = (state_q != S_IDLE);
        load_o   = (state_q == S_LOAD);
        en_o     = (state_q == S_RUN) && !stall;
        vld_o    = phase_pt;
        wen_o    = xfer;
        addr_w_o = phase_pt ? seed_cnt_q : '0;
        sel_mm_o = (state_q == S_RUN) ? (phase_q != '0) : 1'b1;
        ren_o    = 1'b0;
        addr_r_o = '0;
        if (state_q == S_SEED) begin
            ren_o    = 1'b1;
            addr_r_o = seed_ptr_q;
        end else if (phase_pt && (seed_cnt_q != ADDR_LAST)) begin
            // prefetch the next MM operand; repeats harmlessly while stalled
            ren_o    = 1'b1;
            addr_r_o = seed_cnt_q + 1'b1;
        end
    end

    assign ctl.busy     = busy_o;
    assign ctl.load     = load_o;
    assign ctl.en       = en_o;
    assign ctl.ren      = ren_o;
    assign ctl.wen      = wen_o;
    assign ctl.vld      = vld_o;
    assign ctl.addr_r   = addr_r_o;
    assign ctl.addr_w   = addr_w_o;
    assign ctl.sel_sr   = sel_sr_q;
    assign ctl.sel_mm   = sel_mm_o;
    assign ctl.done_row = done_row_q;
    assign ctl.done     = done_q;
endmodule

// File: tb/tb_tf_gen_ctrl_flex.sv
`timescale 1ns/1ps
module tb_tf_gen_ctrl_flex;
    localparam int MM_NUM      = 4;
    localparam int SEED_NUM    = 32;
    localparam int MM_LAT      = 5;
    localparam int ROW_NUM_MAX = 4;
    localparam int DEPTH       = SEED_NUM / MM_NUM;
    localparam int AW          = $clog2(DEPTH);
    localparam int SW          = $clog2(ROW_NUM_MAX);

    localparam int K_SEED = 0;
    localparam int K_LOAD = 1;
    localparam int K_XFER = 2;
    localparam int K_DROW = 3;
    localparam int K_DONE = 4;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk     = 0;
    int  n_fail    = 0;
    int  cyc       = 0;
    bit  mon_en    = 1'b0;
    int  model_ptr = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    tf_gen_ctrl_flex_if #(.AW(AW), .SW(SW)) bus();

    tf_gen_ctrl_flex #(
        .MM_NUM(MM_NUM), .SEED_NUM(SEED_NUM), .MM_LAT(MM_LAT), .ROW_NUM_MAX(ROW_NUM_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ctl  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic string kname(int k);
        case (k)
            K_SEED:  return "seed_read";
            K_LOAD:  return "load";
            K_XFER:  return "transfer";
            K_DROW:  return "done_row";
            K_DONE:  return "done";
            default: return "unknown";
        endcase
    endfunction

    function automatic ev_t mk(int c, int k, int v);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        return e;
    endfunction

    function automatic void chk(string name, int act, int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endfunction

    // Pops the next expected event and compares kind, cycle and value.
    // Returns the expected value when the kind matched, else -1.
    function automatic int see(int kind, int val);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: got value %0d at cycle %0d, expected no event", kname(kind), val, cyc);
            return -1;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc || e.val != val) begin
            n_fail++;
            $display("FAIL event_%s: got %s val %0d at cycle %0d, expected %s val %0d at cycle %0d",
                     kname(kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
        end
        return (e.kind == kind) ? e.val : -1;
    endfunction

    // ------------------------------------------------------------------
    // monitor: observes DUT events and checks them against the scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        int xv;
        if (mon_en && rst_n) begin
            if (bus.ren && !bus.vld) xv = see(K_SEED, int'(bus.addr_r));
            if (bus.load)            xv = see(K_LOAD, 0);
            if (bus.vld && bus.out_rdy) begin
                xv = see(K_XFER, int'(bus.addr_w));
                if (xv >= 0) begin
                    chk("prefetch_ren",  int'(bus.ren),    (xv != DEPTH-1) ? 1 : 0);
                    chk("prefetch_addr", int'(bus.addr_r), (xv != DEPTH-1) ? xv + 1 : 0);
                end
            end
            if (bus.vld && !bus.out_rdy) begin
                chk("stall_en",  int'(bus.en),  0);
                chk("stall_wen", int'(bus.wen), 0);
            end
            if (bus.wen || bus.vld) chk("wen_handshake", int'(bus.wen), (bus.vld && bus.out_rdy) ? 1 : 0);
            if (bus.done_row)       xv = see(K_DROW, 0);
            if (bus.done) begin
                xv = see(K_DONE, int'(bus.sel_sr));
                chk("done_busy", int'(bus.busy), 0);
            end
        end
    end

    task automatic check_idle(input string tag, input int exp_sel_sr);
        chk({tag, "_busy"},     int'(bus.busy),     0);
        chk({tag, "_load"},     int'(bus.load),     0);
        chk({tag, "_en"},       int'(bus.en),       0);
        chk({tag, "_ren"},      int'(bus.ren),      0);
        chk({tag, "_wen"},      int'(bus.wen),      0);
        chk({tag, "_vld"},      int'(bus.vld),      0);
        chk({tag, "_addr_r"},   int'(bus.addr_r),   0);
        chk({tag, "_addr_w"},   int'(bus.addr_w),   0);
        chk({tag, "_sel_sr"},   int'(bus.sel_sr),   exp_sel_sr);
        chk({tag, "_sel_mm"},   int'(bus.sel_mm),   1);
        chk({tag, "_done_row"}, int'(bus.done_row), 0);
        chk({tag, "_done"},     int'(bus.done),     0);
    endtask

    // ------------------------------------------------------------------
    // one job: build the expected event list from the rules, then drive
    // stall_k    : transfer index in row 0 forced to stall for 3 cycles (-1 none)
    // abort_row  : row during whose RUN phase abort is pulsed (-1 none)
    // ------------------------------------------------------------------
    task automatic run_job(input int rows, input bit fst, input int stall_pct,
                           input int stall_k, input int abort_row);
        ev_t ev[$];
        bit  low[int];
        bit  pp[int];
        int  s, t, p, tx, a, last, ptr, loads, end_c, busy_end, st, exp_sr;
        @(posedge clk); #1;
        s     = cyc;
        ptr   = fst ? 0 : model_ptr;
        a     = -1;
        tx    = s;
        if (rows == 0) begin
            ev.push_back(mk(s + 2, K_DONE, 0));
        end else begin
            t = s + 1;
            ev.push_back(mk(t, K_SEED, ptr));
            for (int r = 0; r < rows; r++) begin
                ev.push_back(mk(t + 1, K_LOAD, 0));
                p = t + 1 + MM_LAT;
                for (int k = 0; k < DEPTH; k++) begin
                    st = ($urandom_range(99) < stall_pct) ? int'($urandom_range(3, 1)) : 0;
                    if (r == 0 && k == stall_k) st = 3;
                    for (int j = 0; j < st; j++) low[p + j] = 1'b1;
                    tx = p + st;
                    pp[tx] = 1'b1;
                    ev.push_back(mk(tx, K_XFER, k));
                    p = tx + MM_LAT;
                end
                if (r == abort_row) a = int'($urandom_range(tx, t + 2));
                t = tx + 1;
                if (r < rows - 1) ev.push_back(mk(t, K_SEED, (ptr + r + 1) % DEPTH));
                ev.push_back(mk(t, K_DROW, 0));
            end
            ev.push_back(mk(t + 1, K_DONE, rows % ROW_NUM_MAX));
        end

        // keep only what happens up to and including the abort cycle
        last  = s;
        loads = 0;
        foreach (ev[i]) begin
            if (a < 0 || ev[i].cyc <= a) begin
                exp_q.push_back(ev[i]);
                if (ev[i].kind == K_LOAD) loads++;
                if (ev[i].cyc > last) last = ev[i].cyc;
            end
        end
        if (a >= 0) last = a;
        model_ptr = (ptr + loads) % DEPTH;
        exp_sr    = (a >= 0) ? 0 : rows % ROW_NUM_MAX;
        busy_end  = (a >= 0) ? a : last - 1;
        end_c     = last + 2;

        for (int c = s; c <= end_c; c++) begin
            if (c != s) begin
                @(posedge clk); #1;
            end
            if (c == s) begin
                bus.start   = 1'b1;
                bus.first   = fst;
                bus.row_num = (SW+1)'(rows);
            end else if (c <= busy_end && (c == s + 1 || $urandom_range(15) == 0)) begin
                // start while busy must be ignored
                bus.start   = 1'b1;
                bus.first   = 1'($urandom_range(1));
                bus.row_num = (SW+1)'($urandom_range(7));
            end else begin
                bus.start = 1'b0;
            end
            bus.out_rdy = low.exists(c) ? 1'b0 : (pp.exists(c) ? 1'b1 : 1'($urandom_range(1)));
            bus.abort   = (c == a);
        end
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.out_rdy = 1'b1;
        check_idle("job_end", exp_sr);
        chk("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int rows, ab;
        bus.start   = 1'b0;
        bus.first   = 1'b0;
        bus.row_num = '0;
        bus.out_rdy = 1'b1;
        bus.abort   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset", 0);
        rst_n = 1'b1;

        // asynchronous reset in the middle of RUN
        @(posedge clk); #1;
        bus.start = 1'b1; bus.first = 1'b1; bus.row_num = 3'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (18) @(posedge clk);
        #3;
        chk("pre_reset_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check_idle("async_reset", 0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        model_ptr = 0;
        mon_en    = 1'b1;

        run_job(1, 1'b1, 0, -1, -1);   // single row, no stall
        run_job(4, 1'b1, 0, -1, -1);   // four rows, sel_sr wraps
        run_job(1, 1'b1, 0,  2, -1);   // 3-cycle stall at third vld
        run_job(4, 1'b1, 0, -1,  1);   // abort in row 2 of 4
        run_job(2, 1'b0, 0, -1, -1);   // resumes at seed pointer 2
        run_job(0, 1'b1, 0, -1, -1);   // empty job

        for (int i = 0; i < 8; i++) begin
            rows = int'($urandom_range(4));
            ab   = (rows > 0 && $urandom_range(3) == 0) ? int'($urandom_range(rows - 1)) : -1;
            run_job(rows, 1'($urandom_range(1)), 20, -1, ab);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
